stream_fork_dynamic_buffered: RTL and testbench

Dynamic stream fork with data and per-output buffering. Each input beat carries data and, via a separate selection stream, an output bitmask. The beat is copied into a FIFO in front of every selected output, so selected outputs drain independently and a slow consumer does not stall the others until its FIFO fills. It sits between a single producer and N consumers in interconnect and DMA paths, and adds no combinational path from any output ready to the input ready.

---
 rtl/stream_fork_dynamic_buffered.sv | 116 +++++++++++
 tb/tb_stream_fork_dynamic_buffered.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/stream_fork_dynamic_buffered.sv
// Dynamic stream fork: each accepted beat is copied into a per-output FIFO chosen by a mask.
// Define STREAM_FORK_DYNAMIC_ZERO_SEL_DROP_EN to drop all-zero masks; otherwise they broadcast.
module stream_fork_dynamic_buffered #(
    parameter int unsigned N_OUP      = 2,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 2
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          flush_i,
    input  logic                          valid_i,
    output logic                          ready_o,
    input  logic [DATA_WIDTH-1:0]         data_i,
    input  logic [N_OUP-1:0]              sel_i,
    input  logic                          sel_valid_i,
    output logic                          sel_ready_o,
    output logic [N_OUP-1:0]              valid_o,
    input  logic [N_OUP-1:0]              ready_i,
    output logic [N_OUP*DATA_WIDTH-1:0]   data_o
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [DATA_WIDTH-1:0] mem  [N_OUP][DEPTH];
    logic [PW-1:0]         wptr [N_OUP];
    logic [PW-1:0]         rptr [N_OUP];
    logic [CW-1:0]         cnt  [N_OUP];

    logic [N_OUP-1:0] eff_mask;
    logic [N_OUP-1:0] push;
    logic [N_OUP-1:0] pop;
    logic             space_ok;
    logic             accept;

`ifdef STREAM_FORK_DYNAMIC_ZERO_SEL_DROP_EN
    assign eff_mask = sel_i;
`else
    assign eff_mask = (sel_i == '0) ? '1 : sel_i;
`endif

    // Space is judged on registered counts only, so a full FIFO popping this cycle still blocks.
    always_comb begin
        space_ok = !flush_i;
        for (int unsigned i = 0; i < N_OUP; i++) begin
            if (eff_mask[i] && (cnt[i] == CW'(DEPTH))) space_ok = 1'b0;
        end
    end

    assign accept      = valid_i & sel_valid_i & space_ok;
    assign ready_o     = sel_valid_i & space_ok;
    assign sel_ready_o = valid_i & space_ok;
    assign push        = accept ? eff_mask : '0;

    always_comb begin
        pop    = '0;
        data_o = '0;
        for (int unsigned i = 0; i < N_OUP; i++) begin
            valid_o[i]                         = (cnt[i] != '0);
            pop[i]                             = valid_o[i] & ready_i[i] & !flush_i;
            data_o[i*DATA_WIDTH +: DATA_WIDTH] = mem[i][rptr[i]];
        end
    end

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < N_OUP; i++) begin
                wptr[i] <= '0;
                rptr[i] <= '0;
                cnt[i]  <= '0;
            end
        end else if (flush_i) begin
            for (int unsigned i = 0; i < N_OUP; i++) begin
                wptr[i] <= '0;
                rptr[i] <= '0;
                cnt[i]  <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < N_OUP; i++) begin
                if (push[i]) wptr[i] <= ptr_inc(wptr[i]);
                if (pop[i])  rptr[i] <= ptr_inc(rptr[i]);
                case ({push[i], pop[i]})
                    2'b10:   cnt[i] <= cnt[i] + CW'(1);
                    2'b01:   cnt[i] <= cnt[i] - CW'(1);
                    default: cnt[i] <= cnt[i];
                endcase
            end
        end
    end

    // Storage carries no reset; contents are only observable while the count is non-zero.
    always_ff @(posedge clk_i) begin
        for (int unsigned i = 0; i < N_OUP; i++) begin
            if (push[i]) mem[i][wptr[i]] <= data_i;
        end
    end

    if (N_OUP < 1) begin : g_bad_n_oup
        $error("N_OUP must be at least 1");
    end
    if (DEPTH < 1) begin : g_bad_depth
        $error("DEPTH must be at least 1");
    end

`ifndef SYNTHESIS
    a_data_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (valid_i && !ready_o) |=> (!valid_i || $stable(data_i)));
    a_sel_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (sel_valid_i && !sel_ready_o) |=> (!sel_valid_i || $stable(sel_i)));
`endif

endmodule

// File: tb/tb_stream_fork_dynamic_buffered.sv
// Scoreboard bench for stream_fork_dynamic_buffered: DUT A (3 outputs, depth 2), DUT B (3 outputs, depth 1).
// Expected zero-mask behaviour follows STREAM_FORK_DYNAMIC_ZERO_SEL_DROP_EN.
module tb_stream_fork_dynamic_buffered;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        flush_a = 0, valid_a = 0, selv_a = 0, ready_a, selr_a;
    logic [31:0] data_a = '0;
    logic [2:0]  sel_a = '0, vo_a, ri_a = '0;
    logic [95:0] do_a;

    logic        flush_b = 0, valid_b = 0, selv_b = 0, ready_b, selr_b;
    logic [31:0] data_b = '0;
    logic [2:0]  sel_b = '0, vo_b, ri_b = '0;
    logic [95:0] do_b;

    stream_fork_dynamic_buffered #(.N_OUP(3), .DATA_WIDTH(32), .DEPTH(2)) dut_a (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush_a),
        .valid_i(valid_a), .ready_o(ready_a), .data_i(data_a),
        .sel_i(sel_a), .sel_valid_i(selv_a), .sel_ready_o(selr_a),
        .valid_o(vo_a), .ready_i(ri_a), .data_o(do_a)
    );

    stream_fork_dynamic_buffered #(.N_OUP(3), .DATA_WIDTH(32), .DEPTH(1)) dut_b (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush_b),
        .valid_i(valid_b), .ready_o(ready_b), .data_i(data_b),
        .sel_i(sel_b), .sel_valid_i(selv_b), .sel_ready_o(selr_b),
        .valid_o(vo_b), .ready_i(ri_b), .data_o(do_b)
    );

    int checks = 0;
    int errors = 0;
    logic [31:0] qa0[$], qa1[$], qa2[$], qb0[$], qb1[$], qb2[$];

`ifdef STREAM_FORK_DYNAMIC_ZERO_SEL_DROP_EN
    localparam logic [2:0] ZERO_EFF = 3'b000;
`else
    localparam logic [2:0] ZERO_EFF = 3'b111;
`endif

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic unexpected(input string nm, input logic [31:0] act);
        checks++;
        errors++;
        $display("FAIL %s: got unexpected beat %h expected none", nm, act);
    endtask

    function automatic void push_a(input logic [2:0] m, input logic [31:0] d);
        if (m[0]) qa0.push_back(d);
        if (m[1]) qa1.push_back(d);
        if (m[2]) qa2.push_back(d);
    endfunction

    // Monitor: every output handshake pops and compares the oldest expected beat.
    always @(negedge clk) begin
        if (rst_n && !flush_a) begin
            if (vo_a[0] && ri_a[0]) begin
                if (qa0.size() == 0) unexpected("a0_data", do_a[31:0]);
                else chk("a0_data", do_a[31:0], qa0.pop_front());
            end
            if (vo_a[1] && ri_a[1]) begin
                if (qa1.size() == 0) unexpected("a1_data", do_a[63:32]);
                else chk("a1_data", do_a[63:32], qa1.pop_front());
            end
            if (vo_a[2] && ri_a[2]) begin
                if (qa2.size() == 0) unexpected("a2_data", do_a[95:64]);
                else chk("a2_data", do_a[95:64], qa2.pop_front());
            end
        end
        if (rst_n && !flush_b) begin
            if (vo_b[0] && ri_b[0]) begin
                if (qb0.size() == 0) unexpected("b0_data", do_b[31:0]);
                else chk("b0_data", do_b[31:0], qb0.pop_front());
            end
            if (vo_b[1] && ri_b[1]) begin
                if (qb1.size() == 0) unexpected("b1_data", do_b[63:32]);
                else chk("b1_data", do_b[63:32], qb1.pop_front());
            end
            if (vo_b[2] && ri_b[2]) begin
                if (qb2.size() == 0) unexpected("b2_data", do_b[95:64]);
                else chk("b2_data", do_b[95:64], qb2.pop_front());
            end
        end
    end

    task automatic send_a(input logic [31:0] d, input logic [2:0] s, input logic [2:0] eff);
        bit ok = 0;
        @(posedge clk); #1;
        valid_a = 1; selv_a = 1; data_a = d; sel_a = s;
        for (int n = 0; n < 60; n++) begin
            @(negedge clk);
            if (ready_a) begin ok = 1; break; end
        end
        if (ok) begin
            chk("a_sel_ready", {31'd0, selr_a}, 32'd1);
            push_a(eff, d);
        end else begin
            unexpected("a_accept_timeout", d);
        end
        @(posedge clk); #1;
        valid_a = 0; selv_a = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        @(negedge clk);
        chk("reset_valid_a", {29'd0, vo_a}, 32'd0);
        chk("reset_valid_b", {29'd0, vo_b}, 32'd0);

        // Single fork
        ri_a = 3'b111;
        send_a(32'hA5, 3'b101, 3'b101);
        @(negedge clk);
        chk("fork_valid_c1", {29'd0, vo_a}, 32'b101);
        @(negedge clk);
        chk("fork_valid_c2", {29'd0, vo_a}, 32'd0);

        // Independent drain with output 1 stalled
        @(posedge clk); #1 ri_a = 3'b101;
        send_a(32'd1, 3'b011, 3'b011);
        send_a(32'd2, 3'b011, 3'b011);
        @(posedge clk); #1;
        valid_a = 1; selv_a = 1; data_a = 32'd3; sel_a = 3'b011;
        repeat (3) begin
            @(negedge clk);
            chk("stall_ready", {31'd0, ready_a}, 32'd0);
        end
        @(posedge clk); #1 ri_a = 3'b111;
        send_a(32'd3, 3'b011, 3'b011);
        send_a(32'd4, 3'b011, 3'b011);
        send_a(32'd5, 3'b011, 3'b011);
        send_a(32'd6, 3'b011, 3'b011);
        repeat (8) @(negedge clk);
        chk("drain_empty", qa0.size() + qa1.size() + qa2.size(), 32'd0);

        // Zero mask
        send_a(32'h11, 3'b000, ZERO_EFF);
        @(negedge clk);
        chk("zero_valid", {29'd0, vo_a}, {29'd0, ZERO_EFF});
        repeat (3) @(negedge clk);

        // Full plus pop on the depth-1 instance
        @(posedge clk); #1;
        ri_b = 3'b000; valid_b = 1; selv_b = 1; sel_b = 3'b001; data_b = 32'h40;
        @(negedge clk);
        chk("b_ready_empty", {31'd0, ready_b}, 32'd1);
        qb0.push_back(32'h40);
        @(posedge clk); #1;
        data_b = 32'h41; ri_b = 3'b001;
        @(negedge clk);
        chk("b_ready_full_pop", {31'd0, ready_b}, 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("b_ready_after_pop", {31'd0, ready_b}, 32'd1);
        qb0.push_back(32'h41);
        @(posedge clk); #1;
        valid_b = 0; selv_b = 0;
        repeat (3) @(negedge clk);
        chk("b_empty", qb0.size() + qb1.size() + qb2.size(), 32'd0);
        chk("b_idle_valid", {29'd0, vo_b}, 32'd0);

        // Flush with two beats buffered
        @(posedge clk); #1 ri_a = 3'b000;
        send_a(32'h21, 3'b111, 3'b111);
        send_a(32'h22, 3'b111, 3'b111);
        @(posedge clk); #1;
        flush_a = 1; valid_a = 1; selv_a = 1; sel_a = 3'b001; data_a = 32'h23;
        @(negedge clk);
        chk("flush_ready", {31'd0, ready_a}, 32'd0);
        chk("flush_sel_ready", {31'd0, selr_a}, 32'd0);
        chk("flush_valid_before", {29'd0, vo_a}, 32'b111);
        @(posedge clk); #1;
        flush_a = 0; valid_a = 0; selv_a = 0;
        qa0.delete(); qa1.delete(); qa2.delete();
        @(negedge clk);
        chk("flush_valid_after", {29'd0, vo_a}, 32'd0);

        // Asynchronous reset mid-stream
        send_a(32'h31, 3'b111, 3'b111);
        @(negedge clk);
        chk("pre_reset_valid", {29'd0, vo_a}, 32'b111);
        #2 rst_n = 0;
        #1;
        chk("async_reset_valid", {29'd0, vo_a}, 32'd0);
        qa0.delete(); qa1.delete(); qa2.delete();
        @(posedge clk); #1;
        rst_n = 1; valid_a = 1; selv_a = 1; sel_a = 3'b010; data_a = 32'h55;
        #1;
        chk("post_reset_ready", {31'd0, ready_a}, 32'd1);
        chk("post_reset_sel_ready", {31'd0, selr_a}, 32'd1);
        valid_a = 0;
        #1;
        chk("post_reset_sel_ready_novalid", {31'd0, selr_a}, 32'd0);
        selv_a = 0;
        #1;
        chk("post_reset_ready_noselv", {31'd0, ready_a}, 32'd0);
        repeat (3) @(negedge clk);
        chk("final_valid_a", {29'd0, vo_a}, 32'd0);
        chk("final_queues", qa0.size() + qa1.size() + qa2.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
